bcd_time_counter: RTL and testbench

Parametrised BCD time-of-day counter for the wall-clock design. It generates hours, minutes and seconds as BCD digits from the board clock, with a runtime 12/24-hour display mode, run/hold control and hour/minute set inputs. It sits between the button debouncers and the seven-segment driver. It replaces ad-hoc counting inside the top level, and its digit outputs feed the driver directly.

---
 rtl/bcd_time_counter_pkg.sv | 23 ++
 rtl/bcd_mod_counter.sv | 45 ++++
 rtl/bcd_time_counter.sv | 102 ++++++++++
 tb/tb_bcd_time_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_counter_pkg.sv
// Shared definitions for the BCD time-of-day counter: digit type, roll-over limits
// and the 24h -> 12h display mapping.
package bcd_time_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  // Maps an internal 00-23 BCD hour onto the 12-hour dial (0 -> 12, 13-23 -> 1-11).
  function automatic logic [7:0] hour_12h(input bcd_t tens, input bcd_t units);
    int unsigned h;
    h = 32'(tens) * 10 + 32'(units);
    if (h == 0) begin
      h = 12;
    end else if (h > 12) begin
      h = h - 12;
    end
    return {4'(h / 10), 4'(h % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that rolls MAX -> 00; clr has priority over inc.
module bcd_mod_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  localparam bcd_t MAX_TENS  = 4'(MAX / 10);
  localparam bcd_t MAX_UNITS = 4'(MAX % 10);

  logic at_max_c;

  assign at_max_c = (tens == MAX_TENS) && (units == MAX_UNITS);
  // Carry is combinational so the next stage advances on the same edge.
  assign carry    = inc && !clr && at_max_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= '0;
      units <= '0;
    end else if (clr) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max_c) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= '0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter: prescaler, second/minute/hour chain, set buttons with
// priority over the time advance, and 12/24-hour display mapping.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned PRESCALE_W    = $clog2(TICKS_PER_SEC)
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_N,
  input  logic       run,
  input  logic       mode_24h,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] hours2,
  output logic [3:0] hours1,
  output logic [3:0] mins2,
  output logic [3:0] mins1,
  output logic [3:0] secs2,
  output logic [3:0] secs1,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic                  tick_c;
  logic                  adv_c;
  logic                  sec_carry;
  logic                  min_carry;
  logic                  min_inc_c;
  logic                  hour_inc_c;
  logic                  hour_carry_unused;
  bcd_t                  hr_tens;
  bcd_t                  hr_units;
  logic [7:0]            hr12_c;

  // A set pulse in the same cycle as a tick suppresses that tick's advance.
  assign tick_c     = run && (presc_q == PRESC_LAST);
  assign adv_c      = tick_c && !(inc_min || inc_hour);
  assign min_inc_c  = sec_carry || inc_min;
  assign hour_inc_c = inc_hour || (min_carry && adv_c);

  always_comb begin
    presc_d = presc_q;
    if (inc_min) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = tick_c ? '0 : presc_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q  <= '0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      sec_tick <= tick_c;
      min_tick <= sec_carry;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_secs (
    .clk   (CLK100MHZ),
    .rst_n (RESET_N),
    .inc   (adv_c),
    .clr   (inc_min),
    .tens  (secs2),
    .units (secs1),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_mins (
    .clk   (CLK100MHZ),
    .rst_n (RESET_N),
    .inc   (min_inc_c),
    .clr   (1'b0),
    .tens  (mins2),
    .units (mins1),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hours (
    .clk   (CLK100MHZ),
    .rst_n (RESET_N),
    .inc   (hour_inc_c),
    .clr   (1'b0),
    .tens  (hr_tens),
    .units (hr_units),
    .carry (hour_carry_unused)
  );

  assign hr12_c           = hour_12h(hr_tens, hr_units);
  assign {hours2, hours1} = mode_24h ? {hr_tens, hr_units} : hr12_c;
  assign pm               = (hr_tens == 4'd2) || ((hr_tens == 4'd1) && (hr_units >= 4'd2));

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: a seconds-of-day reference model predicts
// every cycle's outputs, a separate monitor compares them against the DUT.
module tb_bcd_time_counter;

  localparam int TPS = 4;

  logic       CLK100MHZ = 1'b0;
  logic       RESET_N;
  logic       run;
  logic       mode_24h;
  logic       inc_min;
  logic       inc_hour;
  logic [3:0] hours2, hours1, mins2, mins1, secs2, secs1;
  logic       pm, sec_tick, min_tick;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  // Reference state: time as seconds of day plus prescaler phase.
  int t_sec = 0;
  int presc = 0;

  logic [26:0] expq[$];

  bcd_time_counter #(.TICKS_PER_SEC(TPS)) dut (
    .CLK100MHZ (CLK100MHZ),
    .RESET_N   (RESET_N),
    .run       (run),
    .mode_24h  (mode_24h),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .hours2    (hours2),
    .hours1    (hours1),
    .mins2     (mins2),
    .mins1     (mins1),
    .secs2     (secs2),
    .secs1     (secs1),
    .pm        (pm),
    .sec_tick  (sec_tick),
    .min_tick  (min_tick)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  function automatic logic [26:0] exp_vec(input int t, input logic md, input logic st, input logic mt);
    int h, m, s, dh;
    h  = t / 3600;
    m  = (t / 60) % 60;
    s  = t % 60;
    dh = md ? h : ((h % 12 == 0) ? 12 : h % 12);
    return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            (h >= 12), st, mt};
  endfunction

  function automatic logic [26:0] act_vec();
    return {hours2, hours1, mins2, mins1, secs2, secs1, pm, sec_tick, min_tick};
  endfunction

  // One clock cycle of stimulus; the model's prediction for after the edge is queued.
  task automatic step(input logic r, input logic md, input logic im, input logic ih);
    int h, m, s;
    logic tick, mt;
    @(negedge CLK100MHZ);
    run = r; mode_24h = md; inc_min = im; inc_hour = ih;
    tick = r && (presc == TPS - 1);
    h = t_sec / 3600; m = (t_sec / 60) % 60; s = t_sec % 60;
    mt = 1'b0;
    if (im) begin m = (m + 1) % 60; s = 0; end
    if (ih) h = (h + 1) % 24;
    if (!(im || ih) && tick) begin
      mt    = (s == 59);
      t_sec = (t_sec + 1) % 86400;
    end else begin
      t_sec = h * 3600 + m * 60 + s;
    end
    presc = im ? 0 : (r ? (tick ? 0 : presc + 1) : presc);
    expq.push_back(exp_vec(t_sec, md, tick, mt));
  endtask

  task automatic run_cycles(input int n, input logic md);
    for (int i = 0; i < n; i++) step(1'b1, md, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [26:0] exp);
    compared++;
    if (act_vec() !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act_vec(), exp);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input logic md);
    @(posedge CLK100MHZ);
    #3;
    run = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; mode_24h = md;
    RESET_N = 1'b0;
    #1;
    t_sec = 0; presc = 0;
    check_now("async_reset", exp_vec(0, md, 1'b0, 1'b0));
    @(negedge CLK100MHZ);
    RESET_N = 1'b1;
  endtask

  // Monitor: every cycle with a pending prediction is compared just after the edge.
  initial begin
    forever begin
      @(posedge CLK100MHZ);
      #1;
      cycle++;
      if (expq.size() > 0) begin
        logic [26:0] exp;
        exp = expq.pop_front();
        compared++;
        if (act_vec() !== exp) begin
          mismatched++;
          $display("FAIL outputs cycle %0d: got %h expected %h (h h m m s s pm st mt)",
                   cycle, act_vec(), exp);
        end
      end
    end
  end

  initial begin
    RESET_N = 1'b0; run = 1'b0; mode_24h = 1'b1; inc_min = 1'b0; inc_hour = 1'b0;
    repeat (2) @(negedge CLK100MHZ);
    check_now("reset_24h", exp_vec(0, 1'b1, 1'b0, 1'b0));
    mode_24h = 1'b0;
    #1;
    check_now("reset_12h", exp_vec(0, 1'b0, 1'b0, 1'b0));
    mode_24h = 1'b1;
    RESET_N = 1'b1;

    // 60 seconds from reset: one minute and one min_tick.
    run_cycles(60 * TPS, 1'b1);

    // Preload 23:59:59 and roll over midnight.
    for (int i = 0; i < 23; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 58; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycles(59 * TPS, 1'b1);
    run_cycles(TPS + 2, 1'b1);

    // 00:00:30 then inc_min while held, then thirteen hour pulses; view in 12h mode.
    async_reset(1'b1);
    run_cycles(30 * TPS + 1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // inc_min coincident with the tick at 00:05:59.
    async_reset(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycles(59 * TPS + TPS - 1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run_cycles(TPS + 1, 1'b1);

    // Both set pulses together on a tick.
    run_cycles(TPS - 2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);

    // Mid-second reset at 10:20:30, then the first tick timing afterwards.
    async_reset(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycles(30 * TPS + 2, 1'b1);
    async_reset(1'b0);
    run_cycles(2 * TPS + 1, 1'b0);

    // Randomised run/mode/set activity.
    begin
      logic md;
      md = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 99) == 0) md = ~md;
        step($urandom_range(0, 9) != 0, md,
             $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && expq.size() > 0; i++) @(posedge CLK100MHZ);
    #2;
    if (expq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
